// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
// Shares one 16-bit classic Wishbone master port between the instruction
// fetch requester (m0, read-only) and the data load/store requester (m1).
// The winning request is latched, one single-beat Wishbone cycle is run,
// and the winner gets its read data plus a one-cycle ack pulse.
//
// Parameters
//   RR_EN        1 = round-robin between m0/m1, 0 = fixed priority (m1 wins)
//   TIMEOUT_CYC  bus watchdog limit in clocks (2..255), used with the option
//
// Optional feature
//   WB_ARB_TIMEOUT_EN  when defined, a watchdog aborts a BUS phase that has
//                      not been acked after TIMEOUT_CYC clocks, returning
//                      16'hFFFF and pulsing arb_timeout. When undefined the
//                      bus waits indefinitely and arb_timeout is tied low.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   m0_req/m0_adr                fetch request and address
//   m0_ack/m0_rdata              fetch completion pulse and read data
//   m1_req/m1_we/m1_adr/
//   m1_wdata/m1_sel              data request and qualifiers
//   m1_ack/m1_rdata              data completion pulse and read data
//   wb_cyc_o..wb_sel_o           Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i           Wishbone slave response
//   arb_timeout                  one-cycle pulse on watchdog abort
module wb_bus_arbiter #(
  parameter int RR_EN       = 1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [15:0] m0_adr,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_adr,
  input  logic [15:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Out-of-range watchdog limits are rejected at elaboration.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("wb_bus_arbiter: TIMEOUT_CYC must be in 2..255");
  end

  state_t      state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 1 = m1 won last, 0 = m0
  logic        gnt_q, gnt_d;             // current winner, same encoding
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic [15:0] m0_rdata_q, m0_rdata_d;
  logic [15:0] m1_rdata_q, m1_rdata_d;
  logic        pick_m1;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // m1 wins when it is alone, when priority is fixed, or when m0 won last.
  assign pick_m1 = m1_req && (!m0_req || (RR_EN == 0) || !last_gnt_q);

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d      = pick_m1;
          last_gnt_d = pick_m1;
          cyc_d      = 1'b1;
          state_d    = BUS;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d      = 8'd0;
`endif
          if (pick_m1) begin
            we_d  = m1_we;
            adr_d = m1_adr;
            dat_d = m1_wdata;
            sel_d = m1_sel;
          end else begin
            // Fetch is read-only with all lanes enabled.
            we_d  = 1'b0;
            adr_d = m0_adr;
            dat_d = 16'h0000;
            sel_d = 4'hF;
          end
        end
      end
      BUS: begin
        // A slave ack on the watchdog's last cycle still completes normally.
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = RESP;
          if (gnt_q) begin
            m1_ack_d = 1'b1;
            if (!we_q) m1_rdata_d = wb_dat_i;
          end else begin
            m0_ack_d = 1'b1;
            if (!we_q) m0_rdata_d = wb_dat_i;
          end
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (cnt_q == TimeoutLast) begin
          cyc_d     = 1'b0;
          state_d   = RESP;
          timeout_d = 1'b1;
          if (gnt_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = 16'hFFFF;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = 16'hFFFF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset leaves last_gnt pointing at m1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 16'h0000;
      dat_q      <= 16'h0000;
      sel_q      <= 4'h0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= 16'h0000;
      m1_rdata_q <= 16'h0000;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q      <= 8'd0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = sel_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
`ifdef WB_ARB_TIMEOUT_EN
  assign arb_timeout = timeout_q;
`else
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Testbench for wb_bus_arbiter. Instance dutA runs round-robin, dutB runs
// fixed priority; both share every input so their bus timing is identical.
module tb_wb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [15:0] m0_adr;
  logic        m1_req;
  logic        m1_we;
  logic [15:0] m1_adr;
  logic [15:0] m1_wdata;
  logic [3:0]  m1_sel;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;

  logic        m0_ack, m1_ack, wb_cyc_o, wb_stb_o, wb_we_o, arb_timeout;
  logic [15:0] m0_rdata, m1_rdata, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;

  logic        b_m0_ack, b_m1_ack, b_cyc, b_stb, b_we, b_timeout;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_adr, b_dat;
  logic [3:0]  b_sel;

  int checks;
  int errors;

  wb_bus_arbiter #(.RR_EN(1), .TIMEOUT_CYC(16)) dutA (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_adr(m0_adr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .arb_timeout(arb_timeout)
  );

  wb_bus_arbiter #(.RR_EN(0), .TIMEOUT_CYC(16)) dutB (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_adr(m0_adr), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_sel(m1_sel), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_we),
    .wb_adr_o(b_adr), .wb_dat_o(b_dat), .wb_sel_o(b_sel),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .arb_timeout(b_timeout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives the requester side in one go.
  task automatic applyStimulus(input logic r0, input logic [15:0] a0,
                               input logic r1, input logic we,
                               input logic [15:0] a1, input logic [15:0] wd,
                               input logic [3:0] sel);
    m0_req   = r0;
    m0_adr   = a0;
    m1_req   = r1;
    m1_we    = we;
    m1_adr   = a1;
    m1_wdata = wd;
    m1_sel   = sel;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    wb_dat_i = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  initial begin
    bit found;
    int busCnt;
    checks = 0;
    errors = 0;
    $display("[TB] start");

    // Reset state.
    doReset();
    checkOutput("resetBus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o},
                {1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0});
    checkOutput("resetResp", {m0_ack, m1_ack, arb_timeout, m0_rdata, m1_rdata},
                {1'b0, 1'b0, 1'b0, 16'h0, 16'h0});

    // Single fetch with zero-wait slave.
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    checkOutput("fetchBus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
                {1'b1, 1'b1, 1'b0, 4'hF, 16'h0040, 16'h0});
    checkOutput("fetchBusB", {b_cyc, b_stb, b_we, b_sel, b_adr, b_dat},
                {1'b1, 1'b1, 1'b0, 4'hF, 16'h0040, 16'h0});
    checkOutput("fetchNoAckYet", {m0_ack, m1_ack}, 2'b00);
    wb_ack_i = 1'b1;
    wb_dat_i = 16'hA5C3;
    @(negedge clk);
    checkOutput("fetchResp", {wb_cyc_o, wb_stb_o, m0_ack, m1_ack, m0_rdata},
                {1'b0, 1'b0, 1'b1, 1'b0, 16'hA5C3});
    checkOutput("fetchRespB", {b_m0_ack, b_m0_rdata, b_timeout}, {1'b1, 16'hA5C3, 1'b0});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    @(negedge clk);
    checkOutput("fetchAckOneCycle", {m0_ack, m1_ack, wb_cyc_o}, 3'b000);

    // Data write with two wait states.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'h3);
    wb_dat_i = 16'h1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("writeBusStable", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, m1_ack},
                  {1'b1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'h3, 1'b0});
    end
    wb_ack_i = 1'b1;
    @(negedge clk);
    checkOutput("writeResp", {wb_cyc_o, m1_ack, m0_ack, m1_rdata}, {1'b0, 1'b1, 1'b0, 16'h0});
    checkOutput("writeRespB", {b_m1_ack, b_m1_rdata}, {1'b1, 16'h0});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    @(negedge clk);

    // Spurious ack while idle.
    wb_ack_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("spuriousAck", {wb_cyc_o, m0_ack, m1_ack}, 3'b000);
    end
    wb_ack_i = 1'b0;

    // Contention, both requests held: dutA alternates m0,m1; dutB always m1.
    doReset();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0, 4'hF);
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge clk);
        wb_ack_i = wb_cyc_o;
        checkOutput("noAckOverlap", {m0_ack & m1_ack, b_m0_ack & b_m1_ack}, 2'b00);
        if (m0_ack || m1_ack) begin
          found = 1'b1;
          checkOutput("rrGrant", {m0_ack, m1_ack}, (g % 2 == 0) ? 2'b10 : 2'b01);
          checkOutput("fixedGrant", {b_m0_ack, b_m1_ack}, 2'b01);
        end
      end
      if (!found) checkOutput("contentionBudget", 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during BUS, then pending m0 wins the first tie.
    applyStimulus(1'b0, 16'h0300, 1'b1, 1'b0, 16'h0400, 16'h0, 4'hF);
    @(negedge clk);
    checkOutput("preResetBus", {wb_cyc_o, wb_adr_o}, {1'b1, 16'h0400});
    rst = 1'b1;
    m0_req = 1'b1;
    @(negedge clk);
    checkOutput("midReset", {wb_cyc_o, wb_stb_o, m0_ack, m1_ack, b_cyc}, 5'b00000);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postResetGrantA", {wb_cyc_o, wb_we_o, wb_adr_o}, {1'b1, 1'b0, 16'h0300});
    checkOutput("postResetGrantB", {b_cyc, b_adr}, {1'b1, 16'h0400});
    wb_ack_i = 1'b1;
    wb_dat_i = 16'h7E57;
    @(negedge clk);
    checkOutput("postResetAck", {m0_ack, m1_ack, m0_rdata}, {1'b1, 1'b0, 16'h7E57});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    repeat (2) @(negedge clk);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: watchdog aborts after 16 BUS cycles.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0500, 16'h0, 4'hF);
    busCnt = 0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (wb_cyc_o) busCnt++;
      if (m1_ack) begin
        found = 1'b1;
        checkOutput("timeoutResp", {arb_timeout, m1_rdata, wb_cyc_o}, {1'b1, 16'hFFFF, 1'b0});
        checkOutput("timeoutBusCycles", busCnt, 16);
      end
    end
    if (!found) checkOutput("timeoutBudget", 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    @(negedge clk);
    checkOutput("timeoutPulseOne", {arb_timeout, m1_ack}, 2'b00);
    @(negedge clk);

    // Ack on the 16th BUS cycle wins over the watchdog.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0600, 16'h0, 4'hF);
    wb_dat_i = 16'h1357;
    busCnt = 0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (wb_cyc_o) busCnt++;
      wb_ack_i = wb_cyc_o && (busCnt == 16);
      if (m1_ack) begin
        found = 1'b1;
        checkOutput("lateAckResp", {arb_timeout, m1_rdata}, {1'b0, 16'h1357});
      end
    end
    if (!found) checkOutput("lateAckBudget", 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    @(negedge clk);
`else
    // Without the watchdog a stalled slave holds the bus indefinitely.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0500, 16'h0, 4'hF);
    repeat (20) @(negedge clk);
    checkOutput("stallHeld", {wb_cyc_o, m1_ack, arb_timeout, b_timeout}, 4'b1000);
    wb_ack_i = 1'b1;
    wb_dat_i = 16'h2468;
    @(negedge clk);
    checkOutput("stallRelease", {m1_ack, m1_rdata}, {1'b1, 16'h2468});
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 4'h0);
    wb_ack_i = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the CPU's single 16-bit Wishbone master port between two requesters: instruction fetch (m0, read-only) and data load/store (m1).
- Sits between the core's fetch/LSU stages and the external Wishbone bus.
- Registers the winning request, runs exactly one classic single-beat Wishbone cycle per grant, and returns read data plus a one-cycle ack pulse to the winner.

Parameters:
- RR_EN, 1: 1 = round-robin between m0/m1; 0 = fixed priority, m1 (data) always wins.
- TIMEOUT_CYC, 16: bus-cycle watchdog limit in clocks (used only with the optional feature); range 2..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_req  in  1  fetch request, held with m0_adr until m0_ack
- m0_adr  in  16  fetch address
- m0_ack  out  1  one-cycle completion pulse to fetch
- m0_rdata  out  16  fetch read data, valid while m0_ack=1
- m1_req  in  1  data request, held with its qualifiers until m1_ack
- m1_we  in  1  0 = read, 1 = write
- m1_adr  in  16  data address
- m1_wdata  in  16  write data
- m1_sel  in  4  byte/lane select
- m1_ack  out  1  one-cycle completion pulse to data port
- m1_rdata  out  16  data read data, valid while m1_ack=1
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable (low read, high write)
- wb_adr_o  out  16  Wishbone address
- wb_dat_o  out  16  Wishbone write data
- wb_sel_o  out  4  Wishbone select
- wb_dat_i  in  16  Wishbone read data
- wb_ack_i  in  1  Wishbone ack
- arb_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high on rst.
- All outputs are registered. Reset values: all acks, cyc, stb, we, arb_timeout = 0; adr, dat_o, sel, rdata = 0.
- Reset also sets last_gnt = m1, so m0 wins the first tie.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both req: RR_EN=1 grants the requester not equal to last_gnt; RR_EN=0 grants m1.
  - On grant, latch adr/we/wdata/sel (m0 forces we=0, sel=4'hF, dat_o=0), set last_gnt, assert cyc=stb=1 next cycle, go to BUS.
- BUS:
  - cyc/stb and qualifiers held stable until wb_ack_i is sampled high.
  - On the ack edge: latch wb_dat_i into the winner's rdata (reads only; writes leave rdata unchanged), deassert cyc/stb, raise the winner's ack, go to RESP.
- RESP:
  - Ack high for exactly this one cycle; then return to IDLE.
- Requester contract: req and qualifiers are stable from assertion until ack. In the cycle after ack, req reflects the next request or is 0.
- Latency: req first visible in IDLE at cycle T; cyc/stb high at T+1; with a zero-wait slave (ack at T+1), mX_ack at T+2. Peak throughput is one transfer per 3 cycles. Each extra slave wait state adds 1 cycle.
- wb_ack_i outside BUS is ignored; no state change.
- The loser's req stays pending; it is guaranteed the next grant when RR_EN=1.
- rst asserted in any state: next cycle is IDLE with cyc/stb=0. No ack is issued for the aborted transfer; the requester re-requests after reset.
- m0_ack and m1_ack are never high in the same cycle.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUS and increments each BUS cycle without wb_ack_i.
  - When the count reaches TIMEOUT_CYC-1 with no ack: drop cyc/stb, go to RESP, pulse the winner's ack with rdata=16'hFFFF, and pulse arb_timeout for 1 cycle (same cycle as the ack).
  - A wb_ack_i arriving on the same cycle as the limit wins: normal completion, no timeout.
- Undefined:
  - No counter; BUS waits indefinitely.
  - arb_timeout is tied to 0.

Test Plan:
- Single fetch: m0_req=1, m0_adr=16'h0040; slave acks in the first stb cycle with dat_i=16'hA5C3 -> cyc/stb high 1 cycle, wb_we_o=0, wb_sel_o=4'hF, m0_ack pulse 1 cycle later with m0_rdata=16'hA5C3.
- Data write with 2 wait states: m1_we=1, adr=16'h1234, wdata=16'hBEEF, sel=4'h3 -> wb outputs stable for 3 cycles, m1_ack 1 cycle after wb_ack_i, m1_rdata unchanged.
- Contention, RR_EN=1: both req held continuously after reset -> grant order m0, m1, m0, m1; acks never overlap. Same stimulus with RR_EN=0 -> m1 on every grant while m1_req is held.
- Spurious ack: wb_ack_i=1 in IDLE -> no state change, no mX_ack.
- Reset mid-transfer: rst=1 during BUS -> cyc/stb=0 next cycle, no ack. After release, a pending m0_req is granted first.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: slave never acks -> cyc drops after 16 BUS cycles; arb_timeout and m1_ack pulse together with m1_rdata=16'hFFFF. Repeat with ack on cycle 16 -> normal completion, arb_timeout=0.
